// File: rtl/robm_pkg.sv
// Shared constants for the robm controller and its golden monitors.
package robm_pkg;

    localparam int unsigned X_W  = 12;
    localparam int unsigned Y_W  = 10;
    localparam int unsigned ST_W = 3;

    // Controller state codes; code 0 never appears in a healthy controller.
    localparam logic [ST_W-1:0] S_ILLEGAL = 3'd0;
    localparam logic [ST_W-1:0] S1        = 3'd1;
    localparam logic [ST_W-1:0] S2        = 3'd2;
    localparam logic [ST_W-1:0] S3        = 3'd3;
    localparam logic [ST_W-1:0] S4        = 3'd4;
    localparam logic [ST_W-1:0] S5        = 3'd5;
    localparam logic [ST_W-1:0] S6        = 3'd6;
    localparam logic [ST_W-1:0] S7        = 3'd7;

    // One-hot output constants: yi lives in bit i-1.
    localparam logic [Y_W-1:0] Y1  = 10'b00_0000_0001;
    localparam logic [Y_W-1:0] Y2  = 10'b00_0000_0010;
    localparam logic [Y_W-1:0] Y3  = 10'b00_0000_0100;
    localparam logic [Y_W-1:0] Y4  = 10'b00_0000_1000;
    localparam logic [Y_W-1:0] Y5  = 10'b00_0001_0000;
    localparam logic [Y_W-1:0] Y6  = 10'b00_0010_0000;
    localparam logic [Y_W-1:0] Y7  = 10'b00_0100_0000;
    localparam logic [Y_W-1:0] Y8  = 10'b00_1000_0000;
    localparam logic [Y_W-1:0] Y9  = 10'b01_0000_0000;
    localparam logic [Y_W-1:0] Y10 = 10'b10_0000_0000;

endpackage

// File: rtl/robm_golden_next.sv
// Unlocked golden robm transition/output table: (state, x) -> (exp_y, next_state).
module robm_golden_next
    import robm_pkg::*;
(
    input  logic [ST_W-1:0] state,
    input  logic [X_W-1:0]  x,
    output logic [Y_W-1:0]  exp_y,
    output logic [ST_W-1:0] next_state
);

    // Mealy table; x[i-1] is controller input xi. Illegal code recovers to S1 silently.
    always_comb begin
        exp_y      = '0;
        next_state = S1;
        case (state)
            S1: begin
                if (!x[0]) begin
                    next_state = S1;
                end else if (x[10] && x[11]) begin
                    exp_y = Y4;        next_state = S2;
                end else if (x[10]) begin
                    exp_y = Y7 | Y8;   next_state = S3;
                end else if (x[11]) begin
                    if (x[7]) begin
                        exp_y = Y1 | Y2; next_state = S4;
                    end else if (x[4]) begin
                        exp_y = Y2 | Y3; next_state = S4;
                    end else if (x[5]) begin
                        exp_y = Y10;     next_state = S5;
                    end else begin
                        exp_y = Y4;      next_state = S2;
                    end
                end else begin
                    if (x[9] && x[8]) begin
                        exp_y = Y10;     next_state = S5;
                    end else if (x[9]) begin
                        exp_y = Y1 | Y2; next_state = S4;
                    end else if (x[8]) begin
                        exp_y = Y2 | Y3; next_state = S4;
                    end else begin
                        exp_y = Y4;      next_state = S2;
                    end
                end
            end
            S2: begin
                exp_y = Y5; next_state = S1;
            end
            // The locked controller may divert here; the golden copy always takes the true path.
            S3: begin
                exp_y = Y6; next_state = S6;
            end
            S4: begin
                if (x[3]) begin
                    exp_y = Y4; next_state = S2;
                end else begin
                    next_state = S4;
                end
            end
            S5: begin
                if (x[11]) begin
                    exp_y = Y2 | Y9; next_state = S7;
                end else begin
                    exp_y = Y2 | Y3; next_state = S4;
                end
            end
            S6: begin
                if (x[1]) begin
                    exp_y      = x[2] ? (Y1 | Y2) : (Y2 | Y3);
                    next_state = S4;
                end else begin
                    exp_y = Y4; next_state = S2;
                end
            end
            S7: begin
                if (x[6]) begin
                    exp_y = Y2 | Y3; next_state = S4;
                end else begin
                    next_state = S7;
                end
            end
            default: begin
                exp_y      = '0;
                next_state = S1;
            end
        endcase
    end

endmodule

// File: rtl/robm_golden_checker.sv
// Observer comparing robm controller outputs against an unlocked golden FSM copy.
module robm_golden_checker
    import robm_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned CYC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [Y_W-1:0]    exp_y,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    output logic [CYC_W-1:0]  cyc_count,
    output logic [ST_W-1:0]   first_err_state,
    output logic [CYC_W-1:0]  first_err_cyc,
    output logic [ST_W-1:0]   gstate
);

    logic [ST_W-1:0] next_state;
    logic            cmp_fail_c;

    robm_golden_next u_next (
        .state      (gstate),
        .x          (x),
        .exp_y      (exp_y),
        .next_state (next_state)
    );

    // Any compare made from the illegal code is a failure even if y happens to be 0.
    always_comb begin
        cmp_fail_c = (y != exp_y) || (gstate == S_ILLEGAL);
    end

    // Golden state, compare flag, saturating counters and first-error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gstate          <= S1;
            mismatch        <= 1'b0;
            err_sticky      <= 1'b0;
            err_count       <= '0;
            cyc_count       <= '0;
            first_err_state <= '0;
            first_err_cyc   <= '0;
        end else if (en) begin
            gstate   <= next_state;
            mismatch <= cmp_fail_c;
            if (cyc_count != {CYC_W{1'b1}}) begin
                cyc_count <= cyc_count + CYC_W'(1);
            end
            if (cmp_fail_c) begin
                if (err_count != {CNT_W{1'b1}}) begin
                    err_count <= err_count + CNT_W'(1);
                end
                if (!err_sticky) begin
                    err_sticky      <= 1'b1;
                    first_err_state <= gstate;
                    first_err_cyc   <= cyc_count;
                end
            end
        end else begin
            mismatch <= 1'b0;
        end
    end

endmodule

// File: tb/tb_robm_golden_checker.sv
// Self-checking bench for robm_golden_checker against a table-level reference model.
module tb_robm_golden_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] x;
    logic [9:0]  y;
    logic [9:0]  exp_y;
    logic        mismatch;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [15:0] cyc_count;
    logic [2:0]  first_err_state;
    logic [15:0] first_err_cyc;
    logic [2:0]  gstate;

    robm_golden_checker #(.CNT_W(8), .CYC_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .x               (x),
        .y               (y),
        .exp_y           (exp_y),
        .mismatch        (mismatch),
        .err_sticky      (err_sticky),
        .err_count       (err_count),
        .cyc_count       (cyc_count),
        .first_err_state (first_err_state),
        .first_err_cyc   (first_err_cyc),
        .gstate          (gstate)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state, m_errc, m_cyc, m_fes, m_fec;
    bit m_mis, m_sticky;
    logic [9:0] m_exp_pre;
    logic [9:0] obs_exp_pre;

    function automatic logic [9:0] yb(input int n);
        logic [9:0] one;
        one = 10'd1;
        return one << (n - 1);
    endfunction

    function automatic logic [11:0] xb(input int n);
        logic [11:0] one;
        one = 12'd1;
        return one << (n - 1);
    endfunction

    // Golden table written directly from the controller description.
    function automatic void golden(input int st, input logic [11:0] xv,
                                   output logic [9:0] yo, output int nx);
        bit x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12;
        x1 = xv[0]; x2 = xv[1]; x3 = xv[2];  x4 = xv[3];  x5 = xv[4];   x6 = xv[5];
        x7 = xv[6]; x8 = xv[7]; x9 = xv[8];  x10 = xv[9]; x11 = xv[10]; x12 = xv[11];
        yo = '0; nx = 1;
        case (st)
            1: if (!x1)               begin yo = '0;                nx = 1; end
               else if (x11 && x12)   begin yo = yb(4);             nx = 2; end
               else if (x11)          begin yo = yb(7) | yb(8);     nx = 3; end
               else if (x12) begin
                   if (x8)            begin yo = yb(1) | yb(2);     nx = 4; end
                   else if (x5)       begin yo = yb(2) | yb(3);     nx = 4; end
                   else if (x6)       begin yo = yb(10);            nx = 5; end
                   else               begin yo = yb(4);             nx = 2; end
               end else begin
                   if (x10 && x9)     begin yo = yb(10);            nx = 5; end
                   else if (x10)      begin yo = yb(1) | yb(2);     nx = 4; end
                   else if (x9)       begin yo = yb(2) | yb(3);     nx = 4; end
                   else               begin yo = yb(4);             nx = 2; end
               end
            2: begin yo = yb(5); nx = 1; end
            3: begin yo = yb(6); nx = 6; end
            4: if (x4) begin yo = yb(4); nx = 2; end else begin yo = '0; nx = 4; end
            5: if (x12) begin yo = yb(2) | yb(9); nx = 7; end
               else     begin yo = yb(2) | yb(3); nx = 4; end
            6: if (!x2)     begin yo = yb(4);         nx = 2; end
               else if (x3) begin yo = yb(1) | yb(2); nx = 4; end
               else         begin yo = yb(2) | yb(3); nx = 4; end
            7: if (x7) begin yo = yb(2) | yb(3); nx = 4; end else begin yo = '0; nx = 7; end
            default: begin yo = '0; nx = 1; end
        endcase
    endfunction

    function automatic logic [9:0] model_exp(input int st, input logic [11:0] xv);
        logic [9:0] yo;
        int nx;
        golden(st, xv, yo, nx);
        return yo;
    endfunction

    task automatic model_reset();
        m_state = 1; m_errc = 0; m_cyc = 0; m_fes = 0; m_fec = 0;
        m_mis = 0; m_sticky = 0;
    endtask

    // Drive one cycle of inputs, capture the pre-edge exp_y, and advance the model.
    task automatic cycle(input logic e, input logic [11:0] xv, input logic [9:0] yv);
        logic [9:0] ey;
        int nx;
        bit mis;
        en = e; x = xv; y = yv;
        golden(m_state, xv, ey, nx);
        m_exp_pre = ey;
        #1;
        obs_exp_pre = exp_y;
        @(posedge clk);
        #1;
        if (e) begin
            mis = (yv != ey) || (m_state == 0);
            if (mis) begin
                if (!m_sticky) begin
                    m_sticky = 1; m_fes = m_state; m_fec = m_cyc;
                end
                if (m_errc < 255) m_errc++;
            end
            m_mis = mis;
            if (m_cyc < 65535) m_cyc++;
            m_state = nx;
        end else begin
            m_mis = 0;
        end
    endtask

    // Pulse reset between edges with compares disabled, then realign to posedge+1.
    task automatic do_reset();
        en = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; x = '0; y = '0;
        #12;
        checks++; if (gstate !== 3'd1)        begin errors++; $display("FAIL reset_gstate got %0d want 1", gstate); end
        checks++; if (mismatch !== 1'b0)      begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
        checks++; if (err_sticky !== 1'b0)    begin errors++; $display("FAIL reset_sticky got %b want 0", err_sticky); end
        checks++; if (err_count !== 8'd0)     begin errors++; $display("FAIL reset_errc got %0d want 0", err_count); end
        checks++; if (cyc_count !== 16'd0)    begin errors++; $display("FAIL reset_cyc got %0d want 0", cyc_count); end
        checks++; if (first_err_state !== 3'd0) begin errors++; $display("FAIL reset_fes got %0d want 0", first_err_state); end
        checks++; if (first_err_cyc !== 16'd0)  begin errors++; $display("FAIL reset_fec got %0d want 0", first_err_cyc); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_s1_to_s3();
        cycle(1'b1, xb(1) | xb(11), 10'h0C0);
        checks++; if (obs_exp_pre !== 10'h0C0) begin errors++; $display("FAIL s1s3_exp got %h want 0c0", obs_exp_pre); end
        checks++; if (mismatch !== 1'b0)       begin errors++; $display("FAIL s1s3_mismatch got %b want 0", mismatch); end
        checks++; if (gstate !== 3'd3)         begin errors++; $display("FAIL s1s3_gstate got %0d want 3", gstate); end
        #1;
        checks++; if (exp_y !== 10'h020)       begin errors++; $display("FAIL s3_exp got %h want 020", exp_y); end
    endtask

    task automatic test_path();
        logic [11:0] xs [5];
        int want_st [5];
        xs[0] = xb(1) | xb(12) | xb(6); want_st[0] = 5;
        xs[1] = xb(12);                 want_st[1] = 7;
        xs[2] = xb(7);                  want_st[2] = 4;
        xs[3] = xb(4);                  want_st[3] = 2;
        xs[4] = '0;                     want_st[4] = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, xs[i], model_exp(m_state, xs[i]));
            checks++; if (obs_exp_pre !== m_exp_pre) begin errors++; $display("FAIL path_exp step %0d got %h want %h", i, obs_exp_pre, m_exp_pre); end
            checks++; if (gstate !== 3'(want_st[i]))  begin errors++; $display("FAIL path_gstate step %0d got %0d want %0d", i, gstate, want_st[i]); end
            checks++; if (mismatch !== 1'b0)          begin errors++; $display("FAIL path_mismatch step %0d got %b want 0", i, mismatch); end
        end
        checks++; if (err_count !== 8'd0)  begin errors++; $display("FAIL path_errc got %0d want 0", err_count); end
        checks++; if (cyc_count !== 16'd5) begin errors++; $display("FAIL path_cyc got %0d want 5", cyc_count); end
    endtask

    task automatic test_s6_mismatch();
        do_reset();
        cycle(1'b1, xb(1) | xb(11), 10'h0C0);
        cycle(1'b1, 12'd0, 10'h020);
        cycle(1'b1, xb(2) | xb(3), 10'h000);
        checks++; if (obs_exp_pre !== 10'h003)  begin errors++; $display("FAIL s6_exp got %h want 003", obs_exp_pre); end
        checks++; if (mismatch !== 1'b1)        begin errors++; $display("FAIL s6_mismatch got %b want 1", mismatch); end
        checks++; if (err_count !== 8'd1)       begin errors++; $display("FAIL s6_errc got %0d want 1", err_count); end
        checks++; if (first_err_state !== 3'd6) begin errors++; $display("FAIL s6_fes got %0d want 6", first_err_state); end
        checks++; if (first_err_cyc !== 16'd2)  begin errors++; $display("FAIL s6_fec got %0d want 2", first_err_cyc); end
        checks++; if (err_sticky !== 1'b1)      begin errors++; $display("FAIL s6_sticky got %b want 1", err_sticky); end
        checks++; if (gstate !== 3'd4)          begin errors++; $display("FAIL s6_gstate got %0d want 4 (no resync)", gstate); end
    endtask

    task automatic test_saturation();
        logic [11:0] xr;
        for (int i = 0; i < 300; i++) begin
            xr = 12'($urandom);
            cycle(1'b1, xr, ~model_exp(m_state, xr));
            checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL sat_mismatch iter %0d got %b want 1", i, mismatch); end
        end
        checks++; if (err_count !== 8'd255)     begin errors++; $display("FAIL sat_errc got %0d want 255", err_count); end
        checks++; if (first_err_state !== 3'd6) begin errors++; $display("FAIL sat_fes got %0d want 6", first_err_state); end
        checks++; if (first_err_cyc !== 16'd2)  begin errors++; $display("FAIL sat_fec got %0d want 2", first_err_cyc); end
        checks++; if (cyc_count !== 16'(m_cyc)) begin errors++; $display("FAIL sat_cyc got %0d want %0d", cyc_count, m_cyc); end
        checks++; if (gstate !== 3'(m_state))   begin errors++; $display("FAIL sat_gstate got %0d want %0d", gstate, m_state); end
    endtask

    task automatic test_en_low();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 12'($urandom), 10'($urandom));
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL enlow_mismatch iter %0d got %b want 0", i, mismatch); end
        end
        checks++; if (err_count !== 8'(m_errc)) begin errors++; $display("FAIL enlow_errc got %0d want %0d", err_count, m_errc); end
        checks++; if (cyc_count !== 16'(m_cyc)) begin errors++; $display("FAIL enlow_cyc got %0d want %0d", cyc_count, m_cyc); end
        checks++; if (gstate !== 3'(m_state))   begin errors++; $display("FAIL enlow_gstate got %0d want %0d", gstate, m_state); end
    endtask

    task automatic test_random();
        logic [11:0] xr;
        logic [9:0]  yr;
        logic        er;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            xr = 12'($urandom);
            er = ($urandom_range(0, 9) < 8);
            yr = ($urandom_range(0, 9) < 7) ? model_exp(m_state, xr) : 10'($urandom);
            cycle(er, xr, yr);
            checks++; if (obs_exp_pre !== m_exp_pre)      begin errors++; $display("FAIL rnd_exp iter %0d got %h want %h", i, obs_exp_pre, m_exp_pre); end
            checks++; if (mismatch !== m_mis)             begin errors++; $display("FAIL rnd_mismatch iter %0d got %b want %b", i, mismatch, m_mis); end
            checks++; if (gstate !== 3'(m_state))         begin errors++; $display("FAIL rnd_gstate iter %0d got %0d want %0d", i, gstate, m_state); end
            checks++; if (err_count !== 8'(m_errc))       begin errors++; $display("FAIL rnd_errc iter %0d got %0d want %0d", i, err_count, m_errc); end
            checks++; if (cyc_count !== 16'(m_cyc))       begin errors++; $display("FAIL rnd_cyc iter %0d got %0d want %0d", i, cyc_count, m_cyc); end
            checks++; if (err_sticky !== m_sticky)        begin errors++; $display("FAIL rnd_sticky iter %0d got %b want %b", i, err_sticky, m_sticky); end
            checks++; if (first_err_state !== 3'(m_fes))  begin errors++; $display("FAIL rnd_fes iter %0d got %0d want %0d", i, first_err_state, m_fes); end
            checks++; if (first_err_cyc !== 16'(m_fec))   begin errors++; $display("FAIL rnd_fec iter %0d got %0d want %0d", i, first_err_cyc, m_fec); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, xb(1) | xb(12) | xb(6), model_exp(m_state, xb(1) | xb(12) | xb(6)));
        cycle(1'b1, xb(12), 10'h3FF);
        // Assert reset between edges and check it takes effect without a clock.
        #2;
        en = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (gstate !== 3'd1)        begin errors++; $display("FAIL arst_gstate got %0d want 1", gstate); end
        checks++; if (mismatch !== 1'b0)      begin errors++; $display("FAIL arst_mismatch got %b want 0", mismatch); end
        checks++; if (err_sticky !== 1'b0)    begin errors++; $display("FAIL arst_sticky got %b want 0", err_sticky); end
        checks++; if (err_count !== 8'd0)     begin errors++; $display("FAIL arst_errc got %0d want 0", err_count); end
        checks++; if (cyc_count !== 16'd0)    begin errors++; $display("FAIL arst_cyc got %0d want 0", cyc_count); end
        checks++; if (first_err_state !== 3'd0 || first_err_cyc !== 16'd0)
            begin errors++; $display("FAIL arst_first got %0d/%0d want 0/0", first_err_state, first_err_cyc); end
        checks++; if (exp_y !== model_exp(1, x)) begin errors++; $display("FAIL arst_exp got %h want %h", exp_y, model_exp(1, x)); end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        cycle(1'b1, xb(1) | xb(11), 10'h0C0);
        checks++; if (gstate !== 3'd3)     begin errors++; $display("FAIL arst_recover_gstate got %0d want 3", gstate); end
        checks++; if (cyc_count !== 16'd1) begin errors++; $display("FAIL arst_recover_cyc got %0d want 1", cyc_count); end
        checks++; if (mismatch !== 1'b0)   begin errors++; $display("FAIL arst_recover_mismatch got %b want 0", mismatch); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_s1_to_s3();
        test_path();
        test_s6_mismatch();
        test_saturation();
        test_en_low();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
